// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program counter.
// Used by pc_next_sel and program_counter. The optional alignment check
// (macro PC_ALIGN_CHECK_EN) uses the pc_is_misaligned helper below.
package pc_pkg;

    // Default geometry of the RV32I instruction address.
    localparam int          PC_WIDTH        = 32;
    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam int          PC_INC_STEP     = 4;

    typedef logic [PC_WIDTH-1:0] pc_t;

    // Action taken by the PC register on the next rising edge.
    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_e;

    // Priority decode: a load always beats an increment in the same cycle.
    function automatic pc_sel_e pc_sel_decode(input logic load, input logic increment);
        pc_sel_e sel;
        if (load) begin
            sel = PC_LOAD;
        end else if (increment) begin
            sel = PC_INC;
        end else begin
            sel = PC_HOLD;
        end
        return sel;
    endfunction

    // RV32I instructions are word aligned; any nonzero low bit pair is off-word.
    function automatic logic pc_is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage : pc_pkg

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: decodes load/increment into a pc_sel_e
// and produces the candidate next PC. Contains no state; the parent owns
// the PC register.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int WIDTH    = PC_WIDTH,
    parameter int INC_STEP = PC_INC_STEP
) (
    input  logic             i_load,
    input  logic             i_increment,
    input  logic [WIDTH-1:0] i_pc_cur,
    input  logic [WIDTH-1:0] i_pc_target,
    output pc_sel_e          o_sel,
    output logic [WIDTH-1:0] o_pc_next
);

    // Step sized to the address width so the add wraps modulo 2^WIDTH.
    localparam logic [WIDTH-1:0] STEP = WIDTH'(INC_STEP);

    pc_sel_e w_sel;

    // Priority decode of the controls and the matching next-PC mux.
    always_comb begin
        w_sel     = pc_sel_decode(i_load, i_increment);
        o_pc_next = i_pc_cur;
        case (w_sel)
            PC_LOAD: o_pc_next = i_pc_target;
            PC_INC:  o_pc_next = i_pc_cur + STEP;
            default: o_pc_next = i_pc_cur;
        endcase
    end

    assign o_sel = w_sel;

endmodule : pc_next_sel

// File: rtl/program_counter.sv
// Fetch-stage program counter for the RV32I core.
// Holds the current instruction address; each edge it holds, loads a
// branch/jump target or advances by one instruction. Output is purely
// registered. Optional macro PC_ALIGN_CHECK_EN adds a registered
// 'misaligned' flag reflecting the low two bits of the last loaded target.
module program_counter
    import pc_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
    parameter int               INC_STEP     = PC_INC_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             increment,
    input  logic [WIDTH-1:0] instruction_in,
    output logic [WIDTH-1:0] instruction_out
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic             misaligned
`endif
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_next;
    pc_sel_e          w_sel;

    pc_next_sel #(
        .WIDTH    (WIDTH),
        .INC_STEP (INC_STEP)
    ) u_next_sel (
        .i_load      (load),
        .i_increment (increment),
        .i_pc_cur    (r_pc),
        .i_pc_target (instruction_in),
        .o_sel       (w_sel),
        .o_pc_next   (w_pc_next)
    );

    // PC register: async reset to the vector, otherwise enabled whenever the
    // selector asks for a change (hold edges leave the flops untouched).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_VECTOR;
        end else if (w_sel != PC_HOLD) begin
            r_pc <= w_pc_next;
        end
    end

    assign instruction_out = r_pc;

`ifdef PC_ALIGN_CHECK_EN
    logic r_misaligned;

    // Alignment flag: refreshed only on load edges, sticky across inc/hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misaligned <= 1'b0;
        end else if (w_sel == PC_LOAD) begin
            r_misaligned <= pc_is_misaligned(instruction_in[1:0]);
        end
    end

    assign misaligned = r_misaligned;
`endif

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter.
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns after
// the edge (or mid-cycle for the asynchronous reset checks).
module tb_program_counter;

    logic        clk;
    logic        rst;
    logic        load;
    logic        increment;
    logic [31:0] instruction_in;
    logic [31:0] instruction_out;
`ifdef PC_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    program_counter dut (
        .clk             (clk),
        .rst             (rst),
        .load            (load),
        .increment       (increment),
        .instruction_in  (instruction_in),
        .instruction_out (instruction_out)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misaligned      (misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1. Reset for 10 ns with controls idle.
        rst = 1'b1; load = 1'b0; increment = 1'b0; instruction_in = 32'h0;
        #1;
        check("rst_async", instruction_out, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
        check("rst_mis", {31'b0, misaligned}, 32'h0);
`endif
        tick();                               // edge at 5 ns, still in reset
        check("rst_held", instruction_out, 32'h0);
        #4; rst = 1'b0;                       // deassert at 10 ns (falling edge)
        #1;
        check("rst_release", instruction_out, 32'h0);

        // 2. Load 0x20, then hold.
        load = 1'b1; instruction_in = 32'h20;
        tick();
        check("load_20", instruction_out, 32'h20);
        load = 1'b0;
        tick();
        check("hold_20", instruction_out, 32'h20);

        // 3. Three increments, then hold.
        increment = 1'b1;
        tick(); check("inc_24", instruction_out, 32'h24);
        tick(); check("inc_28", instruction_out, 32'h28);
        tick(); check("inc_2c", instruction_out, 32'h2C);
        increment = 1'b0;
        tick(); check("hold_2c", instruction_out, 32'h2C);

        // 4. Load beats increment.
        load = 1'b1; increment = 1'b1; instruction_in = 32'h100;
        tick(); check("load_prio", instruction_out, 32'h100);
        load = 1'b0; increment = 1'b0;

        // instruction_in is ignored on hold edges.
        instruction_in = 32'hDEAD_BEEF;
        tick(); check("in_ignored", instruction_out, 32'h100);

        // 5. Wrap at the top of the address space.
        load = 1'b1; instruction_in = 32'hFFFF_FFFC;
        tick(); check("load_top", instruction_out, 32'hFFFF_FFFC);
        load = 1'b0; increment = 1'b1;
        tick(); check("wrap_0", instruction_out, 32'h0);
        increment = 1'b0;

        // Loaded values are kept verbatim, even off-word.
        load = 1'b1; instruction_in = 32'h22;
        tick(); check("load_22", instruction_out, 32'h22);
`ifdef PC_ALIGN_CHECK_EN
        check("mis_22", {31'b0, misaligned}, 32'h1);
`endif
        load = 1'b0; increment = 1'b1;
        tick(); check("inc_26", instruction_out, 32'h26);
`ifdef PC_ALIGN_CHECK_EN
        check("mis_sticky", {31'b0, misaligned}, 32'h1);
`endif
        increment = 1'b0;
        load = 1'b1; instruction_in = 32'h24;
        tick(); check("load_24", instruction_out, 32'h24);
`ifdef PC_ALIGN_CHECK_EN
        check("mis_24", {31'b0, misaligned}, 32'h0);
        instruction_in = 32'h3;
        tick(); check("load_3", instruction_out, 32'h3);
        check("mis_3", {31'b0, misaligned}, 32'h1);
`endif

        // 6. Reset pulsed mid-cycle while incrementing from 0x40.
        instruction_in = 32'h40;
        tick(); check("load_40", instruction_out, 32'h40);
        load = 1'b0; increment = 1'b1;
        #2; rst = 1'b1;                       // between edges
        #1; check("rst_mid", instruction_out, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
        check("rst_mid_mis", {31'b0, misaligned}, 32'h1 & 32'h0);
`endif
        tick(); check("rst_over_inc", instruction_out, 32'h0);
        #4; rst = 1'b0;                       // release on falling edge
        tick(); check("post_rst_inc", instruction_out, 32'h4);
        increment = 1'b0;
        tick(); check("post_rst_hold", instruction_out, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_program_counter
